// File: rtl/entropy_pkg.sv
// Shared definitions for the entropy collector: FSM encoding, default
// parameter values and a counter-width helper.
package entropy_pkg;

  localparam int unsigned DefWidth        = 64;
  localparam int unsigned DefDecim        = 4;
  localparam int unsigned DefWarmupCycles = 256;
  localparam int unsigned DefRctCutoff    = 32;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWarmup  = 3'd1,
    StCollect = 3'd2,
    StHold    = 3'd3,
    StFail    = 3'd4
  } state_e;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val <= 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/entropy_rct.sv
// Repetition count test on retained raw samples. The run length restarts at 1
// on a value change and counts up on a repeat; o_trip flags the sample that
// brings the run to RCT_CUTOFF.
module entropy_rct
  import entropy_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = DefRctCutoff
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_sample,
  input  logic i_bit,
  output logic o_trip
);

  localparam int unsigned        RunW   = cnt_width(RCT_CUTOFF);
  localparam logic [RunW-1:0]    RunMax = RunW'(RCT_CUTOFF);

  logic            r_last;
  logic            r_seen;
  logic [RunW-1:0] r_run;
  logic [RunW-1:0] w_run_next;

  // Run length after the current sample; saturates at the cutoff.
  always_comb begin
    w_run_next = RunW'(1);
    if (r_seen && (i_bit == r_last)) begin
      w_run_next = (r_run == RunMax) ? r_run : r_run + 1'b1;
    end
  end

  assign o_trip = i_sample && (w_run_next == RunMax);

  // Track last retained value and its run length.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_last <= 1'b0;
      r_seen <= 1'b0;
      r_run  <= '0;
    end else if (i_sample) begin
      r_last <= i_bit;
      r_seen <= 1'b1;
      r_run  <= w_run_next;
    end
  end

endmodule

// File: rtl/entropy_collector.sv
// Entropy collector: warms up an upstream ring oscillator, decimates its
// registered bit stream into WIDTH-bit words and holds each word until the
// consumer accepts it. Define ENTROPY_HEALTH_EN to build in the repetition
// count health test (entropy_rct) and the sticky FAIL state.
module entropy_collector
  import entropy_pkg::*;
#(
  parameter int unsigned WIDTH         = DefWidth,
  parameter int unsigned DECIM         = DefDecim,
  parameter int unsigned WARMUP_CYCLES = DefWarmupCycles,
  parameter int unsigned RCT_CUTOFF    = DefRctCutoff
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear_fail,
  input  logic             raw_bit,
  output logic             osc_en,
  output logic             dff_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             health_fail
);

  localparam int unsigned     WarmW    = cnt_width(WARMUP_CYCLES - 1);
  localparam int unsigned     DecW     = cnt_width(DECIM - 1);
  localparam int unsigned     SampW    = cnt_width(WIDTH - 1);
  localparam logic [WarmW-1:0] WarmLast = WarmW'(WARMUP_CYCLES - 1);
  localparam logic [DecW-1:0]  DecLast  = DecW'(DECIM - 1);
  localparam logic [SampW-1:0] SampLast = SampW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WarmW-1:0] r_wcnt;
  logic [DecW-1:0]  r_dcnt;
  logic [SampW-1:0] r_scnt;
  // Only WIDTH-1 bits are kept; the WIDTH-th sample completes the word.
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_word;
  logic             w_sample;
  logic             w_last_sample;
  logic             w_trip;

  assign w_sample      = (r_state == StCollect) && (r_dcnt == DecLast);
  assign w_last_sample = w_sample && (r_scnt == SampLast);
  assign w_word        = {r_shift, raw_bit};

`ifdef ENTROPY_HEALTH_EN
  logic w_rct_clr;
  assign w_rct_clr = (r_state == StIdle) || (r_state == StFail);

  entropy_rct #(
    .RCT_CUTOFF(RCT_CUTOFF)
  ) u_rct (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_rct_clr),
    .i_sample(w_sample),
    .i_bit   (raw_bit),
    .o_trip  (w_trip)
  );

  assign health_fail = (r_state == StFail);
`else
  // The cutoff only matters when the health test is built in.
  logic w_unused_cutoff;
  assign w_unused_cutoff = (RCT_CUTOFF >= 2);
  assign w_trip          = 1'b0;
  assign health_fail     = 1'b0;
`endif

  // Next-state decode; stop outranks start, handshake and health trips.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (start && !stop) w_state_next = StWarmup;
      StWarmup: begin
        if (stop)                      w_state_next = StIdle;
        else if (r_wcnt == WarmLast)   w_state_next = StCollect;
      end
      StCollect: begin
        if (stop)                      w_state_next = StIdle;
        else if (w_sample && w_trip)   w_state_next = StFail;
        else if (w_last_sample)        w_state_next = StHold;
      end
      StHold: begin
        if (stop)                      w_state_next = StIdle;
        else if (data_ready)           w_state_next = StCollect;
      end
      StFail:    if (clear_fail) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Warmup, decimation and sample counters plus the shift/output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wcnt  <= '0;
      r_dcnt  <= '0;
      r_scnt  <= '0;
      r_shift <= '0;
      r_data  <= '0;
    end else begin
      r_wcnt <= (r_state == StWarmup) ? r_wcnt + 1'b1 : '0;

      if (r_state == StCollect) r_dcnt <= w_sample ? '0 : r_dcnt + 1'b1;
      else                      r_dcnt <= '0;

      if (r_state != StCollect) r_scnt <= '0;
      else if (w_sample)        r_scnt <= w_last_sample ? '0 : r_scnt + 1'b1;

      if (r_state == StIdle) r_shift <= '0;
      else if (w_sample)     r_shift <= w_word[WIDTH-2:0];

      if ((r_state == StCollect) && (w_state_next == StHold)) r_data <= w_word;
    end
  end

  assign osc_en     = (r_state == StWarmup) || (r_state == StCollect) || (r_state == StHold);
  assign dff_en     = osc_en;
  assign data_valid = (r_state == StHold);
  assign busy       = (r_state != StIdle);
  assign data_out   = r_data;

endmodule

// File: tb/tb_entropy_collector.sv
// Directed-plus-random bench for entropy_collector (WIDTH=8, DECIM=2,
// WARMUP_CYCLES=4, RCT_CUTOFF=5). Expected words and timing come from the
// sample schedule: sample k of a run lands base + DECIM*(k+1) cycles after
// the start/handshake cycle, and the word is valid at base + WIDTH*DECIM + 1.
module tb_entropy_collector;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int WU = 4;
  localparam int RC = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         clear_fail = 1'b0;
  logic         raw_bit = 1'b0;
  logic         data_ready = 1'b0;
  logic         osc_en;
  logic         dff_en;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         health_fail;

  int           n_total = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_out = '0;
  logic         trk_last = 1'b0;
  int           trk_run = 0;

  entropy_collector #(
    .WIDTH        (W),
    .DECIM        (D),
    .WARMUP_CYCLES(WU),
    .RCT_CUTOFF   (RC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .clear_fail (clear_fail),
    .raw_bit    (raw_bit),
    .osc_en     (osc_en),
    .dff_en     (dff_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit to drive in cycle c of a run whose collection begins after cycle base.
  function automatic logic raw_for(input int c, input int base, input logic [W-1:0] word);
    int k;
    if (c > base && ((c - base) % D) == 0) begin
      k = (c - base) / D - 1;
      if (k < W) return word[W-1-k];
    end
    return 1'($urandom);
  endfunction

  task automatic track_word(input logic [W-1:0] word);
    for (int i = W - 1; i >= 0; i--) begin
      if (trk_run > 0 && word[i] == trk_last) trk_run++;
      else trk_run = 1;
      trk_last = word[i];
    end
  endtask

  // Random word whose runs, continued from the previous word, stay below the cutoff.
  task automatic gen_word(output logic [W-1:0] word);
    logic b;
    for (int i = W - 1; i >= 0; i--) begin
      b = 1'($urandom);
      if (trk_run >= RC - 1 && b == trk_last) b = ~b;
      if (trk_run > 0 && b == trk_last) trk_run++;
      else trk_run = 1;
      trk_last = b;
      word[i] = b;
    end
  endtask

  // Caller has set start (base=WU) or data_ready (base=0) for cycle 0.
  task automatic run_word(input logic [W-1:0] word, input int base, input bit fail_exp,
                          input string tag);
    int lat;
    lat = base + W * D + 1;
    for (int c = 0; c < lat; c++) begin
      if (c == 1) begin
        chk({tag, "_osc_on"}, {osc_en, dff_en}, 64'h3);
        chk({tag, "_valid_low"}, data_valid, 64'h0);
      end
      if (c == lat - 1) chk({tag, "_valid_early"}, data_valid, 64'h0);
      raw_bit = raw_for(c, base, word);
      tick();
      start = 1'b0;
      data_ready = 1'b0;
    end
    chk({tag, "_valid"}, data_valid, {63'h0, !fail_exp});
    chk({tag, "_health"}, health_fail, {63'h0, fail_exp});
    if (!fail_exp) exp_out = word;
    chk({tag, "_data"}, data_out, exp_out);
  endtask

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] p;
    int           d;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_ctrl", {osc_en, dff_en, data_valid, busy, health_fail}, 64'h0);
    chk("rst_data", data_out, 64'h0);
    rst = 1'b0;
    tick();
    chk("idle_busy", busy, 64'h0);

    // Alternating samples: 8'hAA valid at cycle 21.
    start = 1'b1;
    run_word(8'hAA, WU, 1'b0, "alt");
    track_word(8'hAA);

    // Consumer stalls for 10 cycles: word and valid must hold.
    for (int i = 0; i < 10; i++) begin
      raw_bit = 1'($urandom);
      tick();
      chk("hold_stable", {data_valid, data_out}, {1'b1, exp_out});
    end
    gen_word(w);
    data_ready = 1'b1;
    run_word(w, 0, 1'b0, "next");

    // Stop in HOLD drops valid without handshake; data_out is retained.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_hold", {busy, data_valid, osc_en}, 64'h0);
    chk("stop_hold_data", data_out, exp_out);

    // Stop after three samples, then a fresh full word.
    gen_word(p);
    start = 1'b1;
    for (int c = 0; c <= WU + 3 * D; c++) begin
      raw_bit = raw_for(c, WU, p);
      tick();
      start = 1'b0;
    end
    chk("partial_busy", busy, 64'h1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_collect", {busy, osc_en, dff_en}, 64'h0);
    chk("stop_collect_data", data_out, exp_out);
    gen_word(w);
    start = 1'b1;
    run_word(w, WU, 1'b0, "restart");

    // Start while busy is ignored; random stalls then back-to-back words.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", {data_valid, data_out}, {1'b1, exp_out});
    for (int i = 0; i < 4; i++) begin
      d = int'($urandom_range(0, 3));
      repeat (d) begin
        raw_bit = 1'($urandom);
        tick();
      end
      chk("wait_ready", {data_valid, data_out}, {1'b1, exp_out});
      gen_word(w);
      data_ready = 1'b1;
      run_word(w, 0, 1'b0, "b2b");
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;

`ifdef ENTROPY_HEALTH_EN
    // Constant ones: fifth retained sample trips the repetition count test.
    start = 1'b1;
    raw_bit = 1'b1;
    for (int c = 0; c <= WU + RC * D; c++) begin
      if (c == WU + RC * D) chk("rct_pre", {health_fail, busy}, 64'h1);
      tick();
      start = 1'b0;
    end
    chk("rct_fail", {health_fail, osc_en, dff_en, data_valid, busy}, 64'h11);
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("fail_sticky", {health_fail, busy, osc_en}, 64'h6);
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    chk("fail_clear", {health_fail, busy}, 64'h0);

    // Trip on the word-completing sample discards the word.
    start = 1'b1;
    run_word(8'h5F, WU, 1'b1, "trip_last");
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    chk("trip_clear", {health_fail, busy}, 64'h0);
`else
    // Without the health test a constant stream is just another word.
    start = 1'b1;
    run_word(8'hFF, WU, 1'b0, "ones");
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    chk("no_health", {health_fail, data_valid}, 64'h1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
`endif

    // Reset while holding a valid word.
    gen_word(w);
    start = 1'b1;
    run_word(w, WU, 1'b0, "pre_rst");
    rst = 1'b1;
    tick();
    chk("rst_in_hold", {osc_en, dff_en, data_valid, busy, health_fail}, 64'h0);
    chk("rst_in_hold_data", data_out, 64'h0);
    rst = 1'b0;
    exp_out = '0;

    // Simultaneous start and stop in IDLE: stop wins.
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop", {busy, osc_en}, 64'h0);
    tick();
    chk("start_stop_idle", {busy, osc_en, data_out}, 64'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
